// File: rtl/exu_wbck_arb_pkg.sv
// Shared constants and helpers for the execution-unit writeback arbiter.
// The channel indices name the fixed source ports.
package exu_wbck_arb_pkg;

  localparam int WBCK_XLEN        = 32;
  localparam int WBCK_RFIDX_WIDTH = 5;
  localparam int WBCK_NCH         = 3;

  localparam int WBCK_CH_ALU = 0;
  localparam int WBCK_CH_LSU = 1;
  localparam int WBCK_CH_MDV = 2;

  typedef enum logic {
    ARB_MODE_FIXED = 1'b0,
    ARB_MODE_RR    = 1'b1
  } wbck_arb_mode_e;

  // The round-robin pointer is always at least one bit wide, even with a single channel.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exu_wbck_arb_if.sv
// Writeback bundle: per-channel source requests plus the regfile write port and pending-entry view.
interface exu_wbck_arb_if
  import exu_wbck_arb_pkg::*;
#(
  parameter int NCH         = WBCK_NCH,
  parameter int XLEN        = WBCK_XLEN,
  parameter int RFIDX_WIDTH = WBCK_RFIDX_WIDTH
) ();

  logic [NCH-1:0]             wbck_i_valid;
  logic [NCH-1:0]             wbck_i_ready;
  logic [NCH*XLEN-1:0]        wbck_i_wdat;
  logic [NCH*RFIDX_WIDTH-1:0] wbck_i_rdidx;

  logic                       rf_wbck_o_ready;
  logic                       rf_wbck_o_ena;
  logic [XLEN-1:0]            rf_wbck_o_wdat;
  logic [RFIDX_WIDTH-1:0]     rf_wbck_o_rdidx;

  logic                       wbck_o_pend_vld;
  logic [RFIDX_WIDTH-1:0]     wbck_o_pend_rdidx;

  // Environment side: execution units and the regfile.
  modport master (
    output wbck_i_valid, wbck_i_wdat, wbck_i_rdidx, rf_wbck_o_ready,
    input  wbck_i_ready, rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx,
    input  wbck_o_pend_vld, wbck_o_pend_rdidx
  );

  // Arbiter side.
  modport slave (
    input  wbck_i_valid, wbck_i_wdat, wbck_i_rdidx, rf_wbck_o_ready,
    output wbck_i_ready, rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx,
    output wbck_o_pend_vld, wbck_o_pend_rdidx
  );

endinterface

// File: rtl/wbck_rr_arb.sv
// One-hot request arbiter: fixed priority (lowest index) or round-robin from a pointer
// that advances past the channel whose grant was actually taken.
module wbck_rr_arb
  import exu_wbck_arb_pkg::*;
#(
  parameter int NCH    = WBCK_NCH,
  parameter int ARB_RR = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           take,
  output logic [NCH-1:0] grant
);

  localparam int PTR_W = ptr_width(NCH);
  localparam wbck_arb_mode_e MODE = (ARB_RR != 0 && NCH > 1) ? ARB_MODE_RR : ARB_MODE_FIXED;

  logic [PTR_W-1:0] rr_ptr_reg;
  logic [PTR_W-1:0] rr_ptr_next;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] idx;
  logic [PTR_W:0]   sum;
  logic             found;

  // Scan NCH candidates starting at the pointer (or at 0 for fixed priority), wrapping once.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    sum       = '0;
    for (int i = 0; i < NCH; i++) begin
      if (MODE == ARB_MODE_RR) begin
        sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(i);
      end else begin
        sum = (PTR_W+1)'(i);
      end
      if (sum >= (PTR_W+1)'(NCH)) begin
        sum = sum - (PTR_W+1)'(NCH);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_comb begin
    rr_ptr_next = '0;
    if (grant_idx != PTR_W'(NCH-1)) begin
      rr_ptr_next = grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (MODE == ARB_MODE_RR && take && found) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

endmodule

// File: rtl/exu_wbck_arb.sv
// Writeback arbiter: picks one execution-unit result per cycle into a single hold entry
// that drives the regfile write port; x0 entries retire without a write.
module exu_wbck_arb
  import exu_wbck_arb_pkg::*;
#(
  parameter int NCH         = WBCK_NCH,
  parameter int XLEN        = WBCK_XLEN,
  parameter int RFIDX_WIDTH = WBCK_RFIDX_WIDTH,
  parameter int ARB_RR      = 0
) (
  input  logic          clk,
  input  logic          rst,
  exu_wbck_arb_if.slave wb
);

  logic [NCH-1:0]         grant;
  logic                   drain;
  logic                   can_take;
  logic                   any_grant;

  logic                   hold_vld_reg;
  logic [XLEN-1:0]        hold_wdat_reg;
  logic [RFIDX_WIDTH-1:0] hold_rdidx_reg;

  logic [XLEN-1:0]        ch_wdat  [NCH];
  logic [RFIDX_WIDTH-1:0] ch_rdidx [NCH];
  logic [XLEN-1:0]        sel_wdat;
  logic [RFIDX_WIDTH-1:0] sel_rdidx;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign ch_wdat[gi]  = wb.wbck_i_wdat[gi*XLEN +: XLEN];
      assign ch_rdidx[gi] = wb.wbck_i_rdidx[gi*RFIDX_WIDTH +: RFIDX_WIDTH];
    end
  endgenerate

  // Grant is one-hot or zero, so an AND-OR mux is sufficient.
  always_comb begin
    sel_wdat  = '0;
    sel_rdidx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        sel_wdat  = sel_wdat  | ch_wdat[i];
        sel_rdidx = sel_rdidx | ch_rdidx[i];
      end
    end
  end

  assign drain     = hold_vld_reg & (wb.rf_wbck_o_ready | (hold_rdidx_reg == '0));
  assign can_take  = ~hold_vld_reg | drain;
  assign any_grant = |grant;

  wbck_rr_arb #(
    .NCH    (NCH),
    .ARB_RR (ARB_RR)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (wb.wbck_i_valid),
    .take  (can_take),
    .grant (grant)
  );

  assign wb.wbck_i_ready = grant & {NCH{can_take}};

  // Retire and refill may happen in the same cycle; an empty grant just clears the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld_reg   <= 1'b0;
      hold_wdat_reg  <= '0;
      hold_rdidx_reg <= '0;
    end else if (can_take) begin
      hold_vld_reg <= any_grant;
      if (any_grant) begin
        hold_wdat_reg  <= sel_wdat;
        hold_rdidx_reg <= sel_rdidx;
      end
    end
  end

  assign wb.rf_wbck_o_ena     = hold_vld_reg & wb.rf_wbck_o_ready & (hold_rdidx_reg != '0);
  assign wb.rf_wbck_o_wdat    = hold_wdat_reg;
  assign wb.rf_wbck_o_rdidx   = hold_rdidx_reg;
  assign wb.wbck_o_pend_vld   = hold_vld_reg;
  assign wb.wbck_o_pend_rdidx = hold_rdidx_reg;

endmodule

// File: tb/tb_exu_wbck_arb.sv
// Directed and randomized checks of the writeback arbiter, fixed-priority and round-robin instances.
module tb_exu_wbck_arb;
  import exu_wbck_arb_pkg::*;

  typedef logic [36:0] ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  ent_t q [2][$];

  logic [2:0] rr_order [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [4:0] rr_prev  [6] = '{5'd0, 5'd10, 5'd11, 5'd12, 5'd10, 5'd11};

  exu_wbck_arb_if #(.NCH(3), .XLEN(32), .RFIDX_WIDTH(5)) if_f ();
  exu_wbck_arb_if #(.NCH(3), .XLEN(32), .RFIDX_WIDTH(5)) if_r ();

  exu_wbck_arb #(.NCH(3), .XLEN(32), .RFIDX_WIDTH(5), .ARB_RR(0)) u_fix (
    .clk (clk),
    .rst (rst),
    .wb  (if_f.slave)
  );

  exu_wbck_arb #(.NCH(3), .XLEN(32), .RFIDX_WIDTH(5), .ARB_RR(1)) u_rr (
    .clk (clk),
    .rst (rst),
    .wb  (if_r.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_ch(input int w, input int k, input logic [4:0] ri, input logic [31:0] wd);
    if (w == 0) begin
      if_f.wbck_i_rdidx[k*5 +: 5]  = ri;
      if_f.wbck_i_wdat[k*32 +: 32] = wd;
    end else begin
      if_r.wbck_i_rdidx[k*5 +: 5]  = ri;
      if_r.wbck_i_wdat[k*32 +: 32] = wd;
    end
  endtask

  // Scoreboard step for one instance, called at the sampling point of each cycle.
  task automatic sb(input int w, input logic [2:0] v, input logic [2:0] rdy,
                    input logic [95:0] wd, input logic [14:0] ri, input logic rfr,
                    input logic pv, input logic [4:0] pr, input logic [4:0] orr,
                    input logic [31:0] ow, input logic en);
    string p;
    ent_t  e;
    p = (w == 0) ? "f" : "r";
    chk({p, "_onehot"}, 64'($onehot0(rdy)), 64'd1);
    chk({p, "_grant_valid"}, 64'(rdy & ~v), 64'd0);
    chk({p, "_sb_depth"}, 64'(q[w].size()), pv ? 64'd1 : 64'd0);
    if (pv && q[w].size() > 0) begin
      e = q[w][0];
      chk({p, "_sb_rdidx"}, 64'(pr), 64'(e[36:32]));
      chk({p, "_sb_out_rdidx"}, 64'(orr), 64'(e[36:32]));
      chk({p, "_sb_wdat"}, 64'(ow), 64'(e[31:0]));
      chk({p, "_sb_ena"}, 64'(en), 64'(rfr && (e[36:32] != 5'd0)));
      if (rfr || e[36:32] == 5'd0) begin
        void'(q[w].pop_front());
      end
    end else begin
      chk({p, "_idle_ena"}, 64'(en), 64'd0);
    end
    for (int k = 0; k < 3; k++) begin
      if (v[k] && rdy[k]) begin
        q[w].push_back({ri[k*5 +: 5], wd[k*32 +: 32]});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    if_f.wbck_i_valid = '0; if_f.wbck_i_wdat = '0; if_f.wbck_i_rdidx = '0; if_f.rf_wbck_o_ready = 1'b1;
    if_r.wbck_i_valid = '0; if_r.wbck_i_wdat = '0; if_r.wbck_i_rdidx = '0; if_r.rf_wbck_o_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_ena", 64'(if_f.rf_wbck_o_ena), 64'd0);
    chk("rst_wdat", 64'(if_f.rf_wbck_o_wdat), 64'd0);
    chk("rst_rdidx", 64'(if_f.rf_wbck_o_rdidx), 64'd0);
    chk("rst_pend_vld", 64'(if_f.wbck_o_pend_vld), 64'd0);
    chk("rst_pend_rdidx", 64'(if_f.wbck_o_pend_rdidx), 64'd0);
    chk("rst_rr_pend_vld", 64'(if_r.wbck_o_pend_vld), 64'd0);
    drv();
    rst = 1'b0;

    // Fixed priority, all three channels valid, producers drop valid once accepted
    set_ch(0, 0, 5'd5, 32'hA0); set_ch(0, 1, 5'd6, 32'hA1); set_ch(0, 2, 5'd7, 32'hA2);
    if_f.wbck_i_valid = 3'b111;
    smp();
    chk("fix_c0_ready", 64'(if_f.wbck_i_ready), 64'b001);
    chk("fix_c0_ena", 64'(if_f.rf_wbck_o_ena), 64'd0);
    drv(); if_f.wbck_i_valid = 3'b110;
    smp();
    chk("fix_c1_ena", 64'(if_f.rf_wbck_o_ena), 64'd1);
    chk("fix_c1_rdidx", 64'(if_f.rf_wbck_o_rdidx), 64'd5);
    chk("fix_c1_wdat", 64'(if_f.rf_wbck_o_wdat), 64'hA0);
    chk("fix_c1_ready", 64'(if_f.wbck_i_ready), 64'b010);
    drv(); if_f.wbck_i_valid = 3'b100;
    smp();
    chk("fix_c2_ena", 64'(if_f.rf_wbck_o_ena), 64'd1);
    chk("fix_c2_rdidx", 64'(if_f.rf_wbck_o_rdidx), 64'd6);
    chk("fix_c2_ready", 64'(if_f.wbck_i_ready), 64'b100);
    drv(); if_f.wbck_i_valid = 3'b000;
    smp();
    chk("fix_c3_ena", 64'(if_f.rf_wbck_o_ena), 64'd1);
    chk("fix_c3_rdidx", 64'(if_f.rf_wbck_o_rdidx), 64'd7);
    chk("fix_c3_wdat", 64'(if_f.rf_wbck_o_wdat), 64'hA2);
    drv();
    smp();
    chk("fix_c4_ena", 64'(if_f.rf_wbck_o_ena), 64'd0);
    chk("fix_c4_pend_vld", 64'(if_f.wbck_o_pend_vld), 64'd0);
    drv();

    // Round-robin, all valid held for six cycles
    set_ch(1, 0, 5'd10, 32'hB0); set_ch(1, 1, 5'd11, 32'hB1); set_ch(1, 2, 5'd12, 32'hB2);
    if_r.wbck_i_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      smp();
      chk($sformatf("rr_grant%0d", i), 64'(if_r.wbck_i_ready), 64'(rr_order[i]));
      if (i > 0) begin
        chk($sformatf("rr_rdidx%0d", i), 64'(if_r.rf_wbck_o_rdidx), 64'(rr_prev[i]));
        chk($sformatf("rr_ena%0d", i), 64'(if_r.rf_wbck_o_ena), 64'd1);
      end
      drv();
    end
    if_r.wbck_i_valid = 3'b000;
    smp();
    chk("rr_last_rdidx", 64'(if_r.rf_wbck_o_rdidx), 64'd12);
    chk("rr_last_ready", 64'(if_r.wbck_i_ready), 64'd0);
    drv(); if_r.wbck_i_valid = 3'b101;
    smp();
    chk("rr_wrap_ready", 64'(if_r.wbck_i_ready), 64'b001);
    drv(); if_r.wbck_i_valid = 3'b000;
    smp();
    chk("rr_wrap_rdidx", 64'(if_r.rf_wbck_o_rdidx), 64'd10);
    drv();

    // Regfile stall with a held entry
    if_f.rf_wbck_o_ready = 1'b0;
    set_ch(0, 0, 5'd9, 32'hDEADBEEF);
    if_f.wbck_i_valid = 3'b001;
    smp();
    chk("stall_load_ready", 64'(if_f.wbck_i_ready), 64'b001);
    drv();
    if_f.wbck_i_valid = 3'b010;
    set_ch(0, 1, 5'd4, 32'h55);
    for (int i = 0; i < 3; i++) begin
      smp();
      chk($sformatf("stall%0d_ena", i), 64'(if_f.rf_wbck_o_ena), 64'd0);
      chk($sformatf("stall%0d_wdat", i), 64'(if_f.rf_wbck_o_wdat), 64'hDEADBEEF);
      chk($sformatf("stall%0d_rdidx", i), 64'(if_f.rf_wbck_o_rdidx), 64'd9);
      chk($sformatf("stall%0d_pend", i), 64'({if_f.wbck_o_pend_vld, if_f.wbck_o_pend_rdidx}), 64'h29);
      chk($sformatf("stall%0d_ready", i), 64'(if_f.wbck_i_ready), 64'd0);
      drv();
    end
    if_f.rf_wbck_o_ready = 1'b1;
    smp();
    chk("stall_rel_ena", 64'(if_f.rf_wbck_o_ena), 64'd1);
    chk("stall_rel_rdidx", 64'(if_f.rf_wbck_o_rdidx), 64'd9);
    chk("stall_rel_ready", 64'(if_f.wbck_i_ready), 64'b010);
    drv(); if_f.wbck_i_valid = 3'b000;
    smp();
    chk("stall_next_rdidx", 64'(if_f.rf_wbck_o_rdidx), 64'd4);
    chk("stall_next_wdat", 64'(if_f.rf_wbck_o_wdat), 64'h55);
    chk("stall_next_ena", 64'(if_f.rf_wbck_o_ena), 64'd1);
    drv();
    smp();
    chk("stall_empty", 64'(if_f.wbck_o_pend_vld), 64'd0);
    drv();

    // x0 entry retires with regfile stalled and lets the next channel in
    if_f.rf_wbck_o_ready = 1'b0;
    set_ch(0, 1, 5'd0, 32'h1234);
    if_f.wbck_i_valid = 3'b010;
    smp();
    chk("x0_load_ready", 64'(if_f.wbck_i_ready), 64'b010);
    drv();
    set_ch(0, 0, 5'd3, 32'hCAFE);
    if_f.wbck_i_valid = 3'b001;
    smp();
    chk("x0_pend", 64'({if_f.wbck_o_pend_vld, if_f.wbck_o_pend_rdidx}), 64'h20);
    chk("x0_wdat", 64'(if_f.rf_wbck_o_wdat), 64'h1234);
    chk("x0_ena", 64'(if_f.rf_wbck_o_ena), 64'd0);
    chk("x0_refill_ready", 64'(if_f.wbck_i_ready), 64'b001);
    drv(); if_f.wbck_i_valid = 3'b000;
    smp();
    chk("r3_pend", 64'({if_f.wbck_o_pend_vld, if_f.wbck_o_pend_rdidx}), 64'h23);
    chk("r3_ena", 64'(if_f.rf_wbck_o_ena), 64'd0);

    // Asynchronous reset while r3 is held
    #2 rst = 1'b1;
    #1;
    chk("arst_pend_vld", 64'(if_f.wbck_o_pend_vld), 64'd0);
    chk("arst_pend_rdidx", 64'(if_f.wbck_o_pend_rdidx), 64'd0);
    chk("arst_rdidx", 64'(if_f.rf_wbck_o_rdidx), 64'd0);
    chk("arst_wdat", 64'(if_f.rf_wbck_o_wdat), 64'd0);
    chk("arst_ena", 64'(if_f.rf_wbck_o_ena), 64'd0);
    if_f.rf_wbck_o_ready = 1'b1;
    drv(); rst = 1'b0;
    smp();
    chk("post_rst_ena0", 64'(if_f.rf_wbck_o_ena), 64'd0);
    chk("post_rst_pend0", 64'(if_f.wbck_o_pend_vld), 64'd0);
    drv();
    smp();
    chk("post_rst_ena1", 64'(if_f.rf_wbck_o_ena), 64'd0);
    drv();

    // Randomized traffic on both instances against in-order scoreboards
    for (int c = 0; c < 3000; c++) begin
      if_f.wbck_i_valid = 3'($urandom_range(0, 7));
      if_r.wbck_i_valid = 3'($urandom_range(0, 7));
      if_f.wbck_i_wdat  = {$urandom(), $urandom(), $urandom()};
      if_r.wbck_i_wdat  = {$urandom(), $urandom(), $urandom()};
      if_f.wbck_i_rdidx = 15'($urandom());
      if_r.wbck_i_rdidx = 15'($urandom());
      if_f.rf_wbck_o_ready = ($urandom_range(0, 3) != 0);
      if_r.rf_wbck_o_ready = ($urandom_range(0, 3) != 0);
      smp();
      sb(0, if_f.wbck_i_valid, if_f.wbck_i_ready, if_f.wbck_i_wdat, if_f.wbck_i_rdidx,
         if_f.rf_wbck_o_ready, if_f.wbck_o_pend_vld, if_f.wbck_o_pend_rdidx,
         if_f.rf_wbck_o_rdidx, if_f.rf_wbck_o_wdat, if_f.rf_wbck_o_ena);
      sb(1, if_r.wbck_i_valid, if_r.wbck_i_ready, if_r.wbck_i_wdat, if_r.wbck_i_rdidx,
         if_r.rf_wbck_o_ready, if_r.wbck_o_pend_vld, if_r.wbck_o_pend_rdidx,
         if_r.rf_wbck_o_rdidx, if_r.rf_wbck_o_wdat, if_r.rf_wbck_o_ena);
      drv();
    end
    if_f.wbck_i_valid = '0; if_r.wbck_i_valid = '0;
    if_f.rf_wbck_o_ready = 1'b1; if_r.rf_wbck_o_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      smp();
      sb(0, if_f.wbck_i_valid, if_f.wbck_i_ready, if_f.wbck_i_wdat, if_f.wbck_i_rdidx,
         if_f.rf_wbck_o_ready, if_f.wbck_o_pend_vld, if_f.wbck_o_pend_rdidx,
         if_f.rf_wbck_o_rdidx, if_f.rf_wbck_o_wdat, if_f.rf_wbck_o_ena);
      sb(1, if_r.wbck_i_valid, if_r.wbck_i_ready, if_r.wbck_i_wdat, if_r.wbck_i_rdidx,
         if_r.rf_wbck_o_ready, if_r.wbck_o_pend_vld, if_r.wbck_o_pend_rdidx,
         if_r.rf_wbck_o_rdidx, if_r.rf_wbck_o_wdat, if_r.rf_wbck_o_ena);
      drv();
    end
    chk("f_sb_drained", 64'(q[0].size()), 64'd0);
    chk("r_sb_drained", 64'(q[1].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
